// File: rtl/pls_adapter.sv
// pls_adapter: adapts the local-move probability threshold from windowed
// acceptance statistics of local versus global MCMC moves.
//
// Handshake: a move result is taken on a rising edge when
// in_enable & in_valid & out_ready are all high. out_ready is high only while
// collecting, so results presented during the single update cycle are
// dropped. in_is_local/in_accepted are only looked at when a result is taken.
module pls_adapter #(
  parameter int WIDTH    = 8,
  parameter int WINDOW   = 16,
  parameter int STEP     = 4,
  parameter int PLS_INIT = 50,
  parameter int PLS_MIN  = 8,
  parameter int PLS_MAX  = 248
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_enable,
  input  logic             in_valid,
  input  logic             in_is_local,
  input  logic             in_accepted,
  output logic             out_ready,
  output logic [WIDTH-1:0] out_pls,
  output logic             out_updated
);

  localparam int CW = $clog2(WINDOW + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    UPDATE  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   lt, la, gt, ga, n;
  logic            take;
  logic            upd_q;
  logic [2*CW-1:0] prod_l;
  logic [2*CW-1:0] prod_g;
  logic [WIDTH:0]  pls_wide;
  logic [WIDTH-1:0] pls_up;
  logic [WIDTH-1:0] pls_dn;
  logic [WIDTH-1:0] pls_next;

  assign take = in_enable & in_valid & out_ready;

  // State register; a low enable freezes the FSM wherever it is.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state <= COLLECT;
    end else if (in_enable) begin
      state <= state_next;
    end
  end

  // Next state and ready: the WINDOW-th sample moves us to the update cycle.
  always_comb begin
    state_next = state;
    out_ready  = 1'b0;
    case (state)
      COLLECT: begin
        out_ready = 1'b1;
        if (take && (n == CW'(WINDOW - 1))) state_next = UPDATE;
      end
      UPDATE: begin
        state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Window statistics; cleared by the update cycle.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      lt <= '0; la <= '0; gt <= '0; ga <= '0; n <= '0;
    end else if (in_enable) begin
      if (state == UPDATE) begin
        lt <= '0; la <= '0; gt <= '0; ga <= '0; n <= '0;
      end else if (take) begin
        n <= n + CW'(1);
        if (in_is_local) begin
          lt <= lt + CW'(1);
          la <= la + CW'(in_accepted);
        end else begin
          gt <= gt + CW'(1);
          ga <= ga + CW'(in_accepted);
        end
      end
    end
  end

  // Cross-multiplied rates avoid a divider: la/lt vs ga/gt.
  assign prod_l = (2*CW)'(la) * (2*CW)'(gt);
  assign prod_g = (2*CW)'(ga) * (2*CW)'(lt);

  // Saturating step in WIDTH+1 bits so neither end can wrap.
  assign pls_wide = {1'b0, out_pls};
  assign pls_up = (pls_wide + (WIDTH+1)'(STEP) > (WIDTH+1)'(PLS_MAX)) ?
                  WIDTH'(PLS_MAX) : out_pls + WIDTH'(STEP);
  assign pls_dn = (pls_wide < (WIDTH+1)'(PLS_MIN + STEP)) ?
                  WIDTH'(PLS_MIN) : out_pls - WIDTH'(STEP);

  // Decision: a side with no moves pulls the threshold toward itself first.
  always_comb begin
    pls_next = out_pls;
    if (lt == '0)             pls_next = pls_up;
    else if (gt == '0)        pls_next = pls_dn;
    else if (prod_l > prod_g) pls_next = pls_up;
    else if (prod_l < prod_g) pls_next = pls_dn;
  end

  // Threshold register; only the update cycle writes it.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      out_pls <= WIDTH'(PLS_INIT);
    end else if (in_enable && (state == UPDATE)) begin
      out_pls <= pls_next;
    end
  end

  // Update pulse; cleared by any disabled edge so it never reappears late.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= in_enable && (state == UPDATE);
    end
  end

  assign out_updated = upd_q & in_enable;

endmodule
